// File: rtl/rv_lsu.sv
// Load/store unit: serialises one 32-bit RV32I load/store into little-endian
// byte accesses on a byte-wide memory and returns the extended load result.
module rv_lsu #(
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic       req_illegal, req_misal;
    logic [1:0] req_last;
    logic [7:0] wbyte;
    logic [31:0] ext_data;

    // Request decode: index of the last byte (size-1), legality and alignment.
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   req_last = 2'd1;
            2'b10:   req_last = 2'd3;
            default: req_last = 2'd0;
        endcase
        if (req_we)
            req_illegal = (req_funct3 > 3'd2);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        req_misal = !ALLOW_MISALIGNED &&
                    (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        buf_d      = buf_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    buf_d    = '0;
                    cnt_d    = 2'd0;
                    last_d   = req_last;
                    err_d    = req_illegal || req_misal;
                    // Error path skips memory entirely and leaves mem_addr untouched.
                    if (req_illegal || req_misal) begin
                        state_d = RESP;
                    end else begin
                        state_d    = XFER;
                        mem_addr_d = req_addr;
                    end
                end
            end
            XFER: begin
                if (!we_q)
                    buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                if (cnt_q == last_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            buf_q      <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            buf_q      <= buf_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Outputs decode from registered state only; nothing flows from req_* to mem_*.
    always_comb begin
        case (cnt_q)
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
        case (funct3_q)
            3'b000:  ext_data = {{24{buf_q[7]}}, buf_q[7:0]};
            3'b001:  ext_data = {{16{buf_q[15]}}, buf_q[15:0]};
            3'b100:  ext_data = {24'h0, buf_q[7:0]};
            3'b101:  ext_data = {16'h0, buf_q[15:0]};
            default: ext_data = buf_q;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_we     = (state_q == XFER) && we_q;
    assign mem_wdata  = mem_we ? wbyte : 8'h00;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext_data : 32'h0;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: byte memory model plus a response scoreboard
// holding expected error/data/latency/write-count per request.
module tb_rv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0] mem [0:255] = '{default: 8'h5A};

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwe;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    rv_lsu #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Wait for resp_valid (bounded), then pop and compare against the scoreboard.
    task automatic wait_and_check(input string tag);
        int lat = 0;
        int nwe = 0;
        exp_t e;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (mem_we) nwe++;
            if (resp_valid) break;
        end
        chk({tag, "_timeout"}, {31'h0, resp_valid}, 32'h1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
            chk({tag, "_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_lat"}, lat, e.lat);
            chk({tag, "_nwe"}, nwe, e.nwe);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic e_err, input logic [31:0] e_rdata,
                          input int e_lat, input int e_nwe);
        exp_t e;
        @(negedge clk);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        drive(we, f3, addr, wdata);
        e.err = e_err; e.rdata = e_rdata; e.lat = e_lat; e.nwe = e_nwe;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_and_check(tag);
        @(negedge clk);
        chk({tag, "_ready_after"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        #2;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_req("sw40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0, 5, 4);
        chk("m40", {24'h0, mem[8'h40]}, 32'hEF);
        chk("m41", {24'h0, mem[8'h41]}, 32'hBE);
        chk("m42", {24'h0, mem[8'h42]}, 32'hAD);
        chk("m43", {24'h0, mem[8'h43]}, 32'hDE);

        do_req("lw40",  1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'hDEADBEEF, 5, 0);
        do_req("lb43",  1'b0, 3'b000, 32'h43, 32'h0, 1'b0, 32'hFFFFFFDE, 2, 0);
        do_req("lbu43", 1'b0, 3'b100, 32'h43, 32'h0, 1'b0, 32'h000000DE, 2, 0);
        do_req("lh42",  1'b0, 3'b001, 32'h42, 32'h0, 1'b0, 32'hFFFFDEAD, 3, 0);
        do_req("lhu40", 1'b0, 3'b101, 32'h40, 32'h0, 1'b0, 32'h0000BEEF, 3, 0);

        do_req("lw41_mis", 1'b0, 3'b010, 32'h41, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req("lh41_mis", 1'b0, 3'b001, 32'h41, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req("ld_f011",  1'b0, 3'b011, 32'h40, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req("st_f100",  1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0, 1, 0);
        chk("m40_after_err", {24'h0, mem[8'h40]}, 32'hEF);

        do_req("sw_top", 1'b1, 3'b010, 32'hFFFFFFFC, 32'h01020304, 1'b0, 32'h0, 5, 4);
        chk("mFC", {24'h0, mem[8'hFC]}, 32'h04);
        chk("mFF", {24'h0, mem[8'hFF]}, 32'h01);
        do_req("lw_top", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h01020304, 5, 0);
        do_req("sh_54", 1'b1, 3'b001, 32'h54, 32'hFFFF8001, 1'b0, 32'h0, 3, 2);
        do_req("lh_54", 1'b0, 3'b001, 32'h54, 32'h0, 1'b0, 32'hFFFF8001, 3, 0);

        // Back-to-back: valid stays high, fields switch to the load after the store is taken.
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h60, 32'h123456AA);
        e.err = 1'b0; e.rdata = 32'h0; e.lat = 2; e.nwe = 1;
        sb.push_back(e);
        e.err = 1'b0; e.rdata = 32'hFFFFFFAA; e.lat = 2; e.nwe = 0;
        sb.push_back(e);
        @(posedge clk);
        #1 drive(1'b0, 3'b000, 32'h60, 32'h0);
        wait_and_check("b2b_sb");
        @(negedge clk);
        chk("b2b_idle_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_and_check("b2b_lb");
        chk("m60", {24'h0, mem[8'h60]}, 32'hAA);

        // Reset during byte cycle 2 of a word store.
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h50, 32'h11223344);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_hold_mem_we", {31'h0, mem_we}, 32'h0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        chk("m50", {24'h0, mem[8'h50]}, 32'h44);
        chk("m51", {24'h0, mem[8'h51]}, 32'h33);
        chk("m52", {24'h0, mem[8'h52]}, 32'h5A);
        chk("m53", {24'h0, mem[8'h53]}, 32'h5A);
        do_req("lw50", 1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 32'h5A5A3344, 5, 0);

        chk("sb_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
Load/store unit between the rv core datapath and the byte-wide main memory. It accepts one 32-bit load or store request from the execute stage. It serialises the request into little-endian byte accesses, one byte per cycle. For loads it reassembles the bytes and returns a sign- or zero-extended 32-bit result for register write-back.

Parameters:
ADDR_W, 32, width of request and memory byte addresses
ALLOW_MISALIGNED, 0, 0 = misaligned half/word access returns error; 1 = performed bytewise at any address

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (size/sign)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (bits beyond size ignored)
resp_valid  out  1  one-cycle response strobe
resp_err  out  1  request rejected, qualified by resp_valid
resp_rdata  out  32  extended load data, qualified by resp_valid
mem_addr  out  ADDR_W  byte address to memory
mem_we  out  1  byte write enable, memory writes on rising edge
mem_wdata  out  8  byte to write
mem_rdata  in  8  combinational read data for mem_addr

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_we=0, mem_addr=0, mem_wdata=0; byte counter and data buffers cleared.
- States: IDLE, XFER, RESP.
- IDLE, accept rule: req_valid && req_ready at a rising edge. The unit latches we, funct3, addr and wdata, then decodes.
- Size n: funct3 000/100 gives 1. 001/101 gives 2. 010 gives 4.
- Illegal funct3: 011, 110 and 111 for loads; any funct3 other than 000/001/010 for stores.
- Misaligned (ALLOW_MISALIGNED=0): n=2 with addr[0]=1, or n=4 with addr[1:0]!=0.
- Legal request goes to XFER with i=0. Illegal or misaligned request goes directly to RESP with err=1. No memory access occurs on the error path.
- XFER, cycle i (0..n-1):
  - mem_addr = base+i, wrapping modulo 2^ADDR_W.
  - Store: mem_we=1, mem_wdata=wdata[8i+7:8i].
  - Load: mem_we=0; mem_rdata is captured into buffer byte i at the rising edge ending the cycle.
  - After byte n-1, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Load, no error: resp_rdata = assembled bytes. funct3 000 sign-extends bit 7, 001 sign-extends bit 15, 100/101 zero-extend.
  - Store, no error: resp_rdata=0.
  - Error: resp_err=1, resp_rdata=0.
- req_ready=1 only in IDLE. Requests are not accepted during XFER or RESP, and req_valid is ignored there.
- Latency, accept edge to resp_valid high: n+1 cycles legal, 1 cycle error. A back-to-back request may be accepted on the edge that leaves RESP at the earliest. Word load: accept, 4 byte cycles, RESP, so the next accept is 6 edges after the first.
- Outside XFER: mem_we=0, mem_addr holds last value, mem_wdata=0.
- Output timing: outputs are registered or decoded from state only. No combinational path from req_* to mem_*.
- Reset mid-XFER: the transfer is aborted immediately. Store bytes already written stay written; remaining bytes are not written. No response is issued.
- Wrap: a word at 0xFFFFFFFC touches ...FC–...FF. With ALLOW_MISALIGNED=1, addresses past 0xFFFFFFFF wrap to 0.

Test Plan:
- SW 0xDEADBEEF @0x40 (funct3 010) -> mem_we 4 consecutive cycles writing 0x40=EF, 0x41=BE, 0x42=AD, 0x43=DE. resp_valid 5 cycles after accept with err=0, rdata=0.
- LW @0x40 after above -> resp_rdata=0xDEADBEEF. Then LB @0x43 -> 0xFFFFFFDE; LBU @0x43 -> 0x000000DE; LH @0x42 -> 0xFFFFDEAD; LHU @0x40 -> 0x0000BEEF.
- LW @0x41 with ALLOW_MISALIGNED=0 -> resp_valid 1 cycle after accept with err=1, rdata=0, mem_we never asserted. Same parameter, LH @0x42 -> legal.
- Load funct3=011 and store funct3=100 -> err=1, no memory access. req_ready back to 1 the cycle after the response.
- SW 0x11223344 @0x50, reset asserted during byte cycle 2 -> 0x50=44, 0x51=33 written, 0x52/0x53 unchanged. No resp_valid; req_ready=1 and mem_we=0 during reset.
- Back-to-back: req_valid held high with SB 0xAA @0x60 then LB @0x60 -> second accepted only in IDLE; LB returns 0xFFFFFFAA.
